// File: rtl/warp_issue_pkg.sv
// Shared sizing, types and helpers for the warp issue scoreboard.
// Holds the widths of the issue bundle fields, the derived warp id width,
// the packed issue bundle carried from an ibuf head to the issue port,
// and the round-robin pointer increment.
package warp_issue_pkg;

    localparam int unsigned NUM_WARPS    = 8;
    localparam int unsigned NUM_LANES    = 16;
    localparam int unsigned ARCH_LEN     = 32;
    localparam int unsigned OP_BITS      = 7;
    localparam int unsigned REG_BITS     = 8;
    localparam int unsigned IMM_BITS     = 32;
    localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS);
    localparam int unsigned NUM_REGS     = 1 << REG_BITS;

    typedef logic [WARP_ID_BITS-1:0] warp_id_t;
    typedef logic [REG_BITS-1:0]     reg_idx_t;

    typedef struct packed {
        logic [ARCH_LEN-1:0]  pc;
        logic [OP_BITS-1:0]   op;
        logic [REG_BITS-1:0]  rd;
        logic [REG_BITS-1:0]  rs1;
        logic [REG_BITS-1:0]  rs2;
        logic [REG_BITS-1:0]  rs3;
        logic [IMM_BITS-1:0]  imm32;
        logic [NUM_LANES-1:0] tmask;
    } issue_bundle_t;

    // Next warp after w, wrapping at NUM_WARPS (which need not be a power of two).
    function automatic warp_id_t next_warp(input warp_id_t w);
        if (32'(w) == NUM_WARPS - 32'd1) begin
            return '0;
        end
        return w + warp_id_t'(1);
    endfunction

endpackage

// File: rtl/warp_scoreboard.sv
// Per-warp register scoreboard.
// Ports: clock/reset (sync, active-high); set port (set_valid, set_wid,
// set_rd) marks a register as having an outstanding write; clear port
// (clear_valid, clear_wid, clear_rd) retires it; rd/rs1/rs2/rs3 are the
// per-warp head register indices, hazard[w] flags any of them pending.
module warp_scoreboard
    import warp_issue_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              set_valid,
    input  warp_id_t                          set_wid,
    input  reg_idx_t                          set_rd,
    input  logic                              clear_valid,
    input  warp_id_t                          clear_wid,
    input  reg_idx_t                          clear_rd,
    input  logic [NUM_WARPS-1:0][REG_BITS-1:0] rd,
    input  logic [NUM_WARPS-1:0][REG_BITS-1:0] rs1,
    input  logic [NUM_WARPS-1:0][REG_BITS-1:0] rs2,
    input  logic [NUM_WARPS-1:0][REG_BITS-1:0] rs3,
    output logic [NUM_WARPS-1:0]              hazard
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] sb;

    // Register 0 is hardwired clean.
    function automatic logic busy(input logic [NUM_REGS-1:0] row, input reg_idx_t r);
        return (r != '0) && row[r];
    endfunction

    // Clear is applied first so a coincident set of the same bit wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            sb <= '0;
        end else begin
            if (clear_valid && (clear_rd != '0)) begin
                sb[clear_wid][clear_rd] <= 1'b0;
            end
            if (set_valid && (set_rd != '0)) begin
                sb[set_wid][set_rd] <= 1'b1;
            end
        end
    end

    // Hazard looks only at registered state; writeback is not bypassed.
    always_comb begin
        hazard = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            hazard[w] = busy(sb[w], rs1[w]) | busy(sb[w], rs2[w]) |
                        busy(sb[w], rs3[w]) | busy(sb[w], rd[w]);
        end
    end

endmodule

// File: rtl/warp_issue_scoreboard.sv
// Warp issue stage: picks one hazard-free ibuf head per cycle by round robin,
// dequeues it and holds it in a single registered issue slot.
// Ports: clock/reset (sync, active-high); ibuf_valid/ibuf_ready and the
// flattened ibuf_bits_* heads (warp g in slice g); issue_valid/issue_ready
// and issue_* fields of the registered issue slot; wb_valid/wb_wid/wb_rd
// retire scoreboard entries.
module warp_issue_scoreboard
    import warp_issue_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_WARPS-1:0]           ibuf_valid,
    output logic [NUM_WARPS-1:0]           ibuf_ready,
    input  logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_bits_pc,
    input  logic [NUM_WARPS*OP_BITS-1:0]   ibuf_bits_op,
    input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_bits_rd,
    input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_bits_rs1,
    input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_bits_rs2,
    input  logic [NUM_WARPS*REG_BITS-1:0]  ibuf_bits_rs3,
    input  logic [NUM_WARPS*IMM_BITS-1:0]  ibuf_bits_imm32,
    input  logic [NUM_WARPS*NUM_LANES-1:0] ibuf_bits_tmask,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [WARP_ID_BITS-1:0]        issue_wid,
    output logic [ARCH_LEN-1:0]            issue_pc,
    output logic [OP_BITS-1:0]             issue_op,
    output logic [REG_BITS-1:0]            issue_rd,
    output logic [REG_BITS-1:0]            issue_rs1,
    output logic [REG_BITS-1:0]            issue_rs2,
    output logic [REG_BITS-1:0]            issue_rs3,
    output logic [IMM_BITS-1:0]            issue_imm32,
    output logic [NUM_LANES-1:0]           issue_tmask,
    input  logic                           wb_valid,
    input  logic [WARP_ID_BITS-1:0]        wb_wid,
    input  logic [REG_BITS-1:0]            wb_rd
);

    issue_bundle_t                      head [NUM_WARPS];
    logic [NUM_WARPS-1:0][REG_BITS-1:0] head_rd, head_rs1, head_rs2, head_rs3;
    logic [NUM_WARPS-1:0]               hazard;
    logic [NUM_WARPS-1:0]               eligible;
    logic                               can_load;
    logic                               grant_valid;
    warp_id_t                           grant_wid;
    logic                               fire;
    warp_id_t                           rr_ptr;
    issue_bundle_t                      issue_q;

    // Unpack the flattened per-warp head fields.
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_head
        assign head_rd[g]  = ibuf_bits_rd[REG_BITS*g +: REG_BITS];
        assign head_rs1[g] = ibuf_bits_rs1[REG_BITS*g +: REG_BITS];
        assign head_rs2[g] = ibuf_bits_rs2[REG_BITS*g +: REG_BITS];
        assign head_rs3[g] = ibuf_bits_rs3[REG_BITS*g +: REG_BITS];
        assign head[g] = '{
            pc:    ibuf_bits_pc[ARCH_LEN*g +: ARCH_LEN],
            op:    ibuf_bits_op[OP_BITS*g +: OP_BITS],
            rd:    head_rd[g],
            rs1:   head_rs1[g],
            rs2:   head_rs2[g],
            rs3:   head_rs3[g],
            imm32: ibuf_bits_imm32[IMM_BITS*g +: IMM_BITS],
            tmask: ibuf_bits_tmask[NUM_LANES*g +: NUM_LANES]
        };
    end

    warp_scoreboard u_sb (
        .clock       (clock),
        .reset       (reset),
        .set_valid   (fire),
        .set_wid     (grant_wid),
        .set_rd      (head_rd[grant_wid]),
        .clear_valid (wb_valid),
        .clear_wid   (wb_wid),
        .clear_rd    (wb_rd),
        .rd          (head_rd),
        .rs1         (head_rs1),
        .rs2         (head_rs2),
        .rs3         (head_rs3),
        .hazard      (hazard)
    );

    assign eligible = ibuf_valid & ~hazard;
    assign can_load = ~issue_valid | issue_ready;

    // First eligible warp at or after rr_ptr, wrapping around.
    always_comb begin
        warp_id_t scan;
        grant_valid = 1'b0;
        grant_wid   = '0;
        scan        = '0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            scan = WARP_ID_BITS'((32'(rr_ptr) + i) % NUM_WARPS);
            if (!grant_valid && eligible[scan]) begin
                grant_valid = 1'b1;
                grant_wid   = scan;
            end
        end
    end

    assign fire       = can_load & grant_valid & ~reset;
    assign ibuf_ready = fire ? (NUM_WARPS'(1) << grant_wid) : '0;

    // Issue slot and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_wid   <= '0;
            issue_q     <= '0;
            rr_ptr      <= '0;
        end else if (fire) begin
            issue_valid <= 1'b1;
            issue_wid   <= grant_wid;
            issue_q     <= head[grant_wid];
            rr_ptr      <= next_warp(grant_wid);
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

    assign issue_pc    = issue_q.pc;
    assign issue_op    = issue_q.op;
    assign issue_rd    = issue_q.rd;
    assign issue_rs1   = issue_q.rs1;
    assign issue_rs2   = issue_q.rs2;
    assign issue_rs3   = issue_q.rs3;
    assign issue_imm32 = issue_q.imm32;
    assign issue_tmask = issue_q.tmask;

endmodule
